// File: rtl/decode_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_hazard_stage
// Brief    : MIPS decode stage: register file, immediate extension, load-use
//            hazard detection, halt/flush control and the ID/EX register.
// Revision : 1.0
// ============================================================================
module decode_hazard_stage #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_R0  = 1,
    parameter int SIGN_EXT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              stop,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [31:0]       instruccion,
    input  logic              reg_write_in,
    input  logic [4:0]        WR,
    input  logic [DATA_W-1:0] WD,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] ext_sig,
    output logic [4:0]        rs_out,
    output logic [4:0]        rt_out,
    output logic [4:0]        rd_out,
    output logic              branch,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              reg_dst,
    output logic              reg_write_out,
    output logic              alu_src,
    output logic [5:0]        alu_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_LOAD   = 2'd2
    } action_t;

    state_t  r_state;
    state_t  w_state_nxt;
    action_t w_action;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic        w_unused_shamt;

    assign w_opcode       = instruccion[31:26];
    assign w_rs           = instruccion[25:21];
    assign w_rt           = instruccion[20:16];
    assign w_rd           = instruccion[15:11];
    assign w_funct        = instruccion[5:0];
    assign w_imm          = instruccion[15:0];
    assign w_unused_shamt = ^instruccion[10:6];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_regs [NREGS];
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_rf_rs;
    logic [DATA_W-1:0] w_rf_rt;
    logic [DATA_W-1:0] w_data1;
    logic [DATA_W-1:0] w_data2;

    assign w_wr_ok = reg_write_in
                   && ({27'd0, WR} < 32'(NREGS))
                   && ((WR != 5'd0) || (ZERO_R0 == 0));

    generate
        for (genvar g = 0; g < NREGS; g++) begin : g_regs
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_regs[g] <= '0;
                end else if (w_wr_ok && (WR == 5'(g))) begin
                    r_regs[g] <= WD;
                end
            end
        end
    endgenerate

    // Unmatched source indices (>= NREGS) fall through to zero
    always_comb begin
        w_rf_rs = '0;
        w_rf_rt = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (w_rs == 5'(i)) w_rf_rs = r_regs[i];
            if (w_rt == 5'(i)) w_rf_rt = r_regs[i];
        end
    end

    // Write-first: a same-cycle accepted write is forwarded to the readers
    assign w_data1 = (w_wr_ok && (WR == w_rs)) ? WD : w_rf_rs;
    assign w_data2 = (w_wr_ok && (WR == w_rt)) ? WD : w_rf_rt;

    // ------------------------------------------------------------------
    // Immediate extension
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_ext;

    generate
        if (DATA_W > 16) begin : g_ext_wide
            assign w_ext = (SIGN_EXT != 0) ? {{(DATA_W-16){w_imm[15]}}, w_imm}
                                           : {{(DATA_W-16){1'b0}}, w_imm};
        end else begin : g_ext_narrow
            assign w_ext = w_imm;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    logic       w_branch;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_mem_to_reg;
    logic       w_reg_dst;
    logic       w_reg_write;
    logic       w_alu_src;
    logic [5:0] w_alu_op;

    always_comb begin
        w_branch     = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_dst    = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_alu_op     = w_opcode;
        case (w_opcode)
            OP_RTYPE: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
                w_alu_op    = w_funct;
            end
            OP_LW: begin
                w_alu_src    = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            OP_SW: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            OP_BEQ: begin
                w_branch = 1'b1;
            end
            OP_ADDI: begin
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hazard detection and stage control
    // ------------------------------------------------------------------
    logic w_hazard;

    assign w_hazard = in_valid && out_valid && mem_read && (rt_out != 5'd0)
                   && ((rt_out == w_rs) || (rt_out == w_rt));

    // Reset term lets an asserted rst drop stall without waiting for clk
    assign stall = (w_hazard || stop) && rst && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_action    = ACT_HOLD;
        if (flush) begin
            w_state_nxt = ST_RUN;
            w_action    = ACT_BUBBLE;
        end else if (stop) begin
            w_state_nxt = ST_HALT;
            w_action    = ACT_BUBBLE;
        end else if (ena) begin
            case (r_state)
                ST_RUN: begin
                    if (w_hazard) begin
                        w_state_nxt = ST_BUBBLE;
                        w_action    = ACT_BUBBLE;
                    end else begin
                        w_action = in_valid ? ACT_LOAD : ACT_BUBBLE;
                    end
                end
                ST_BUBBLE, ST_HALT: begin
                    w_state_nxt = ST_RUN;
                    w_action    = in_valid ? ACT_LOAD : ACT_BUBBLE;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_action    = ACT_BUBBLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            data1         <= '0;
            data2         <= '0;
            ext_sig       <= '0;
            rs_out        <= '0;
            rt_out        <= '0;
            rd_out        <= '0;
            branch        <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_to_reg    <= 1'b0;
            reg_dst       <= 1'b0;
            reg_write_out <= 1'b0;
            alu_src       <= 1'b0;
            alu_op        <= '0;
        end else begin
            case (w_action)
                ACT_BUBBLE: begin
                    out_valid     <= 1'b0;
                    data1         <= '0;
                    data2         <= '0;
                    ext_sig       <= '0;
                    rs_out        <= '0;
                    rt_out        <= '0;
                    rd_out        <= '0;
                    branch        <= 1'b0;
                    mem_read      <= 1'b0;
                    mem_write     <= 1'b0;
                    mem_to_reg    <= 1'b0;
                    reg_dst       <= 1'b0;
                    reg_write_out <= 1'b0;
                    alu_src       <= 1'b0;
                    alu_op        <= '0;
                end
                ACT_LOAD: begin
                    out_valid     <= 1'b1;
                    data1         <= w_data1;
                    data2         <= w_data2;
                    ext_sig       <= w_ext;
                    rs_out        <= w_rs;
                    rt_out        <= w_rt;
                    rd_out        <= w_rd;
                    branch        <= w_branch;
                    mem_read      <= w_mem_read;
                    mem_write     <= w_mem_write;
                    mem_to_reg    <= w_mem_to_reg;
                    reg_dst       <= w_reg_dst;
                    reg_write_out <= w_reg_write;
                    alu_src       <= w_alu_src;
                    alu_op        <= w_alu_op;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_hazard_stage
// Brief    : Scoreboard bench for decode_hazard_stage over three parameter sets.
// Revision : 1.0
// ============================================================================
module tb_decode_hazard_stage;

    typedef struct packed {
        logic        valid;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] ext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_dst;
        logic        reg_write;
        logic        alu_src;
        logic [5:0]  alu_op;
    } idex_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic        stop = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        reg_write_in = 1'b0;
    logic [4:0]  wr = '0;
    logic [31:0] wd = '0;

    logic  stall_w [3];
    idex_t act [3];

    int tests = 0;
    int fails = 0;

    idex_t [2:0] out_q [$];
    logic  [2:0] stall_q [$];

    logic [63:0] rf [3][32];
    idex_t       cur [3];
    logic        prev_stall = 1'b0;

    always #5 clk = ~clk;

    // Three configurations: default, narrow regfile + zero-ext + writable r0, 16-bit datapath
    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int DW = (k == 2) ? 16 : 32;
        localparam int NR = (k == 1) ? 8 : 32;
        localparam int SX = (k == 1) ? 0 : 1;
        localparam int ZR = (k == 1) ? 0 : 1;
        logic [DW-1:0] d1, d2, ex;
        logic [4:0]    rso, rto, rdo;
        logic          st, ov, br, mr, mw, m2r, rdst, rwo, asrc;
        logic [5:0]    aop;

        decode_hazard_stage #(
            .DATA_W(DW), .NREGS(NR), .ZERO_R0(ZR), .SIGN_EXT(SX)
        ) u_dut (
            .clk(clk), .rst(rst), .ena(ena), .stop(stop), .flush(flush),
            .in_valid(in_valid), .instruccion(instr), .reg_write_in(reg_write_in),
            .WR(wr), .WD(wd[DW-1:0]), .stall(st), .out_valid(ov),
            .data1(d1), .data2(d2), .ext_sig(ex),
            .rs_out(rso), .rt_out(rto), .rd_out(rdo),
            .branch(br), .mem_read(mr), .mem_write(mw), .mem_to_reg(m2r),
            .reg_dst(rdst), .reg_write_out(rwo), .alu_src(asrc), .alu_op(aop)
        );

        assign stall_w[k] = st;
        assign act[k] = {ov, 64'(d1), 64'(d2), 64'(ex), rso, rto, rdo,
                         br, mr, mw, m2r, rdst, rwo, asrc, aop};
    end

    function automatic int dw_of(int k);  return (k == 2) ? 16 : 32; endfunction
    function automatic int nr_of(int k);  return (k == 1) ? 8 : 32;  endfunction
    function automatic bit sx_of(int k);  return k != 1;             endfunction
    function automatic bit zr_of(int k);  return k != 1;             endfunction

    function automatic logic [63:0] mask(int k);
        return (64'd1 << dw_of(k)) - 64'd1;
    endfunction

    function automatic bit accepts(int k, logic we, logic [4:0] w);
        return we && (int'(w) < nr_of(k)) && ((w != 5'd0) || !zr_of(k));
    endfunction

    function automatic logic [63:0] rd_model(int k, logic [4:0] s, logic we,
                                             logic [4:0] w, logic [31:0] d);
        if (int'(s) >= nr_of(k)) return 64'd0;
        if (accepts(k, we, w) && (w == s)) return 64'(d) & mask(k);
        return rf[k][s];
    endfunction

    function automatic idex_t decode(int k, logic [31:0] ins, logic [63:0] a, logic [63:0] b);
        idex_t r;
        logic [5:0] op;
        r       = '0;
        op      = ins[31:26];
        r.valid = 1'b1;
        r.d1    = a;
        r.d2    = b;
        r.rs    = ins[25:21];
        r.rt    = ins[20:16];
        r.rd    = ins[15:11];
        r.ext   = (sx_of(k) ? {{48{ins[15]}}, ins[15:0]} : {48'd0, ins[15:0]}) & mask(k);
        r.alu_op = (op == 6'd0) ? ins[5:0] : op;
        case (op)
            6'h00: begin r.reg_dst = 1'b1; r.reg_write = 1'b1; end
            6'h23: begin r.alu_src = 1'b1; r.mem_read = 1'b1; r.mem_to_reg = 1'b1; r.reg_write = 1'b1; end
            6'h2b: begin r.alu_src = 1'b1; r.mem_write = 1'b1; end
            6'h04: r.branch = 1'b1;
            6'h08: begin r.alu_src = 1'b1; r.reg_write = 1'b1; end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rtype(logic [4:0] s, logic [4:0] t, logic [4:0] d, logic [5:0] f);
        return {6'd0, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] s, logic [4:0] t, logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [4:0] a, b, c;
        a = 5'($urandom_range(0, 15));
        b = 5'($urandom_range(0, 15));
        c = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 5))
            0: return rtype(a, b, c, 6'($urandom));
            1: return itype(6'h23, a, b, 16'($urandom));
            2: return itype(6'h2b, a, b, 16'($urandom));
            3: return itype(6'h04, a, b, 16'($urandom));
            4: return itype(6'h08, a, b, 16'($urandom));
            default: return $urandom;
        endcase
    endfunction

    // One cycle of stimulus; the model's view of that cycle goes onto the queues
    task automatic drive(input logic r, input logic en, input logic stp, input logic fl,
                         input logic iv, input logic [31:0] ins, input logic we,
                         input logic [4:0] w, input logic [31:0] d);
        idex_t [2:0] nx;
        logic  [2:0] se;
        logic        hz;
        @(negedge clk);
        rst = r; ena = en; stop = stp; flush = fl; in_valid = iv;
        instr = ins; reg_write_in = we; wr = w; wd = d;
        for (int k = 0; k < 3; k++) begin
            hz = iv && cur[k].valid && cur[k].mem_read && (cur[k].rt != 5'd0)
              && ((cur[k].rt == ins[25:21]) || (cur[k].rt == ins[20:16]));
            se[k] = r && !fl && (hz || stp);
            if (!r) begin
                nx[k] = '0;
                for (int j = 0; j < 32; j++) rf[k][j] = 64'd0;
            end else begin
                if (fl || stp)        nx[k] = '0;
                else if (!en)         nx[k] = cur[k];
                else if (hz || !iv)   nx[k] = '0;
                else nx[k] = decode(k, ins, rd_model(k, ins[25:21], we, w, d),
                                            rd_model(k, ins[20:16], we, w, d));
                if (accepts(k, we, w)) rf[k][w] = 64'(d) & mask(k);
            end
            cur[k] = nx[k];
        end
        stall_q.push_back(se);
        out_q.push_back(nx);
        prev_stall = se[0];
    endtask

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, a, e);
        end
    endtask

    initial begin : mon_stall
        logic [2:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (stall_q.size() > 0) begin
                e = stall_q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    tests++;
                    if (stall_w[k] !== e[k]) begin
                        fails++;
                        $display("FAIL stall dut%0d actual=%b required=%b", k, stall_w[k], e[k]);
                    end
                end
            end
        end
    end

    initial begin : mon_out
        idex_t [2:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (out_q.size() > 0) begin
                e = out_q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    tests++;
                    if (act[k] !== e[k]) begin
                        fails++;
                        $display("FAIL idex dut%0d actual=%h required=%h", k, act[k], e[k]);
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] ins;
        logic        r, en, stp, fl, iv, we;
        logic [4:0]  w;
        for (int k = 0; k < 3; k++) begin
            cur[k] = '0;
            for (int j = 0; j < 32; j++) rf[k][j] = 64'd0;
        end

        drive(0, 0, 0, 0, 0, 32'd0, 0, 5'd0, 32'd0);
        #1;
        chk("reset_valid", 64'(act[0].valid), 64'd0);
        chk("reset_stall", 64'(stall_w[0]), 64'd0);
        drive(0, 1, 0, 0, 1, rtype(1, 2, 3, 6'h20), 1, 5'd4, 32'h55);

        // Same-cycle write of r5 forwarded into add r3,r5,r0
        drive(1, 1, 0, 0, 1, rtype(5, 0, 3, 6'h20), 1, 5'd5, 32'h1234);
        @(posedge clk); #1;
        chk("fwd_data1", act[0].d1, 64'h1234);
        chk("fwd_data2", act[0].d2, 64'h0);
        chk("fwd_ctrl", {62'd0, act[0].reg_dst, act[0].reg_write}, 64'd3);
        chk("fwd_valid", 64'(act[0].valid), 64'd1);

        // Load-use: lw r8 then add r2,r8,r9
        drive(1, 1, 0, 0, 1, itype(6'h23, 1, 8, 16'd4), 0, 5'd0, 32'd0);
        drive(1, 1, 0, 0, 1, rtype(8, 9, 2, 6'h20), 0, 5'd0, 32'd0);
        #1; chk("lu_stall", 64'(stall_w[0]), 64'd1);
        @(posedge clk); #1; chk("lu_bubble", 64'(act[0].valid), 64'd0);
        drive(1, 1, 0, 0, 1, rtype(8, 9, 2, 6'h20), 0, 5'd0, 32'd0);
        #1; chk("lu_stall_once", 64'(stall_w[0]), 64'd0);
        @(posedge clk); #1;
        chk("lu_issue_valid", 64'(act[0].valid), 64'd1);
        chk("lu_issue_rs", 64'(act[0].rs), 64'd8);

        // Flush in the hazard cycle
        drive(1, 1, 0, 0, 1, itype(6'h23, 1, 8, 16'd4), 0, 5'd0, 32'd0);
        drive(1, 1, 0, 1, 1, rtype(8, 9, 2, 6'h20), 0, 5'd0, 32'd0);
        #1; chk("fl_stall", 64'(stall_w[0]), 64'd0);
        @(posedge clk); #1; chk("fl_bubble", 64'(act[0].valid), 64'd0);
        drive(1, 1, 0, 0, 1, rtype(8, 9, 2, 6'h20), 0, 5'd0, 32'd0);
        @(posedge clk); #1;
        chk("fl_next_valid", 64'(act[0].valid), 64'd1);

        // Immediate extension across configurations
        drive(1, 1, 0, 0, 1, itype(6'h08, 0, 4, 16'hFFF0), 0, 5'd0, 32'd0);
        @(posedge clk); #1;
        chk("ext_sign32", act[0].ext, 64'hFFFF_FFF0);
        chk("ext_zero32", act[1].ext, 64'h0000_FFF0);
        chk("ext_16", act[2].ext, 64'hFFF0);

        // r0 and out-of-range writes
        drive(1, 1, 0, 0, 0, 32'd0, 1, 5'd0, 32'hDEAD);
        drive(1, 1, 0, 0, 0, 32'd0, 1, 5'd12, 32'hBEEF);
        drive(1, 1, 0, 0, 1, rtype(0, 12, 1, 6'h20), 0, 5'd0, 32'd0);
        @(posedge clk); #1;
        chk("r0_zero", act[0].d1, 64'h0);
        chk("r0_writable", act[1].d1, 64'hDEAD);
        chk("r12_ignored", act[1].d2, 64'h0);
        chk("r12_written", act[0].d2, 64'hBEEF);

        // Halt for three cycles, then release, then reset during a halt request
        drive(1, 1, 0, 0, 1, itype(6'h08, 2, 3, 16'd7), 0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 1, rtype(3, 4, 5, 6'h20), 0, 5'd0, 32'd0);
            #1; chk("halt_stall", 64'(stall_w[0]), 64'd1);
            @(posedge clk); #1; chk("halt_bubble", 64'(act[0].valid), 64'd0);
        end
        drive(1, 1, 0, 0, 1, rtype(3, 4, 5, 6'h20), 0, 5'd0, 32'd0);
        @(posedge clk); #1;
        chk("halt_release_rd", {58'd0, act[0].valid, act[0].rd}, 64'h25);
        drive(1, 1, 0, 0, 1, rtype(6, 7, 9, 6'h22), 0, 5'd0, 32'd0);
        @(posedge clk); #1;
        chk("halt_once_rd", 64'(act[0].rd), 64'd9);
        drive(1, 1, 1, 0, 1, rtype(6, 7, 9, 6'h22), 0, 5'd0, 32'd0);
        drive(1, 1, 0, 0, 1, itype(6'h2b, 6, 7, 16'h10), 0, 5'd0, 32'd0);
        drive(0, 1, 1, 0, 1, itype(6'h2b, 6, 7, 16'h10), 0, 5'd0, 32'd0);
        #1;
        chk("async_rst_outputs", {63'd0, |act[0]}, 64'd0);
        chk("async_rst_stall", 64'(stall_w[0]), 64'd0);
        drive(1, 1, 0, 0, 1, itype(6'h2b, 6, 7, 16'h10), 0, 5'd0, 32'd0);
        @(posedge clk); #1;
        chk("post_rst_issue", 64'(act[0].valid), 64'd1);

        // Fill the register files, then randomized traffic
        for (int i = 0; i < 32; i++)
            drive(1, 1, 0, 0, 0, 32'd0, 1, 5'(i), $urandom);
        ins = rand_ins();
        iv  = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (!prev_stall) begin
                ins = rand_ins();
                iv  = ($urandom_range(0, 7) != 0);
            end
            r   = ($urandom_range(0, 99) != 0);
            en  = ($urandom_range(0, 9) != 0);
            stp = ($urandom_range(0, 15) == 0);
            fl  = ($urandom_range(0, 19) == 0);
            we  = 1'($urandom_range(0, 1));
            w   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
            drive(r, en, stp, fl, iv, ins, we, w, $urandom);
        end

        @(posedge clk); #3;
        @(posedge clk); #3;
        chk("queues_drained", 64'(out_q.size() + stall_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_hazard_stage.md
DECODE_HAZARD_STAGE -- requirements
Module: decode_hazard_stage

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 32, giving the register, datapath and extension width; legal range 16..64.
REQ-002 The block SHALL have the parameter NREGS, default 32, giving the register file depth; legal range 8..32.
REQ-003 The block SHALL have the parameter ZERO_R0, default 1: when 1, r0 reads as 0 and writes to r0 are ignored.
REQ-004 The block SHALL have the parameter SIGN_EXT, default 1: 1 means sign-extend imm[15:0] to DATA_W; 0 means zero-extend.
REQ-005 The port list SHALL be, with clock and reset first:
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-low reset
  ena  in  1  stage enable; 0 freezes the ID/EX register
  stop  in  1  halt request
  flush  in  1  branch-taken squash
  in_valid  in  1  instruccion is valid
  instruccion  in  32  MIPS-format instruction
  reg_write_in  in  1  writeback enable
  WR  in  5  writeback register
  WD  in  DATA_W  writeback data
  stall  out  1  combinational; fetch holds its instruction while 1
  out_valid  out  1  ID/EX holds a real instruction
  data1, data2  out  DATA_W  registered rs / rt values
  ext_sig  out  DATA_W  registered extended immediate
  rs_out, rt_out, rd_out  out  5  registered register fields
  branch, mem_read, mem_write, mem_to_reg, reg_dst, reg_write_out, alu_src  out  1  registered controls
  alu_op  out  6  registered ALU operation

Function
REQ-006 All outputs except stall SHALL be registered, with a latency of 1 cycle from the sampling edge of instruccion.
REQ-007 Opcode decode SHALL be as follows; every other opcode SHALL decode as a NOP with all controls 0 and out_valid still 1:
  R-type 000000: reg_dst=1, reg_write_out=1, alu_op=funct
  lw 100011: alu_src, mem_read, mem_to_reg, reg_write_out
  sw 101011: alu_src, mem_write
  beq 000100: branch
  addi 001000: alu_src, reg_write_out
  Non-R-type opcodes: alu_op=opcode.
REQ-008 The register file SHALL write on the rising edge when reg_write_in=1, WR<NREGS, and (WR!=0 or ZERO_R0=0).
REQ-009 Register file reads SHALL be write-first: if WR equals the source field in the same cycle and the write is accepted, data1/data2 SHALL capture WD.
REQ-010 A source field >=NREGS SHALL read as 0.
REQ-011 Load-use hazard: hazard=in_valid & out_valid & mem_read & rt_out!=0 & (rt_out==instruccion[25:21] | rt_out==instruccion[20:16]).
REQ-012 stall SHALL equal (hazard | stop) & rst & ~flush.
REQ-013 The FSM SHALL have three states: RUN, BUBBLE, HALT.
  RUN -> BUBBLE on hazard: ID/EX loads a bubble (out_valid=0, all controls 0).
  BUBBLE -> RUN on the next edge; the held instruction then issues.
  Any state -> HALT while stop=1: ID/EX loads a bubble each cycle.
  HALT -> RUN on the first edge with stop=0.
REQ-014 Edge priority SHALL be rst > flush > stop > ~ena > hazard > normal load.
REQ-015 flush=1 SHALL load a bubble, force the state to RUN and suppress stall, regardless of hazard or stop.
REQ-016 ena=0 SHALL hold the ID/EX register and the FSM state, while register file writes continue.
REQ-017 in_valid=0 in RUN SHALL load a bubble.
REQ-018 A hazard SHALL stall for exactly 1 cycle, because the bubble clears mem_read.

Reset
REQ-019 rst=0 SHALL immediately clear all registered outputs, all register file entries and the FSM (state RUN), independent of clk.
REQ-020 Release of rst SHALL be sampled synchronously; the first instruction is accepted on the first edge with rst=1.
REQ-021 rst asserted mid-stall SHALL drop stall combinationally, and no bubble SHALL persist after release.

Verification
REQ-022 Write r5=0x1234 and, in the same cycle, present add r3,r5,r0 -> next cycle data1=0x1234, data2=0, reg_dst=1, reg_write_out=1, out_valid=1.
REQ-023 lw r8,4(r1) followed by add r2,r8,r9 -> stall=1 for exactly 1 cycle, then one bubble (out_valid=0), then add issues with rs_out=8.
REQ-024 Same lw/add sequence with flush=1 in the hazard cycle -> stall=0 and a bubble is loaded; the next instruction issues normally.
REQ-025 SIGN_EXT=1 with imm 0xFFF0 -> ext_sig=0xFFFFFFF0; SIGN_EXT=0 -> ext_sig=0x0000FFF0; with DATA_W=16 -> 0xFFF0.
REQ-026 Write WR=0 with WD=0xDEAD and ZERO_R0=1 -> reading r0 returns 0; with NREGS=8, a write to r12 is ignored and reading r12 returns 0.
REQ-027 stop=1 for 3 cycles during a stream -> 3 bubbles with stall=1; on release the held instruction issues once; asserting rst=0 mid-halt clears all outputs asynchronously.
